// File: rtl/regfile_sb.sv
// Register file with a scoreboard of pending (reserved) registers for deferred writebacks.
// The top index is not stored; reading it returns the r15 input (PC+8).
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 16,
    parameter int MAX_PEND = 4,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             mark_valid,
    input  logic [AW-1:0]    mark_addr,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [WIDTH-1:0] r15,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    output logic [NREGS-1:0] pending,
    output logic [CW-1:0]    pend_cnt,
    output logic             mark_ready,
    output logic             mark_err,
    output logic             wb_err
);
    localparam logic [AW-1:0] TOP = AW'(NREGS - 1);

    logic [WIDTH-1:0] regs [NREGS-1];
    logic             mark_ok;
    logic             mark_rej;
    logic             wb_bad;
    logic [NREGS-1:0] pend_nxt;
    logic [CW-1:0]    cnt_nxt;

    // mark handshake: a reservation is taken on a rising edge where mark_valid
    // and mark_ready are both high and the address is free; mark_valid while
    // mark_ready is low is not held off -- it is rejected and flagged on mark_err.
    assign mark_ready = (pend_cnt < CW'(MAX_PEND));
    assign mark_ok    = mark_valid && mark_ready && (mark_addr != TOP) && !pending[mark_addr];
    assign mark_rej   = mark_valid && !mark_ok;
    // The top index is never pending, so this also flags writebacks to it.
    assign wb_bad     = wb_valid && !pending[wb_addr];

    always_comb begin
        pend_nxt = pending;
        if (wb_valid) pend_nxt[wb_addr] = 1'b0;
        if (mark_ok)  pend_nxt[mark_addr] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS - 1; i++) regs[i] <= '0;
            pending  <= '0;
            pend_cnt <= '0;
            mark_err <= 1'b0;
            wb_err   <= 1'b0;
        end else begin
            // Writeback has priority over the immediate port on an address clash.
            for (int i = 0; i < NREGS - 1; i++) begin
                if (wb_valid && wb_addr == AW'(i))   regs[i] <= wb_data;
                else if (we3 && wa3 == AW'(i))       regs[i] <= wd3;
            end
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
            mark_err <= mark_rej;
            wb_err   <= wb_bad;
        end
    end

    // Returns {busy, data} for one read port, including same-cycle forwarding.
    function automatic logic [WIDTH:0] read_port(input logic [AW-1:0] a);
        logic [WIDTH-1:0] d;
        logic             b;
        d = r15;
        b = 1'b0;
        if (a != TOP) begin
            d = regs[a];
            b = pending[a];
            if (BYPASS != 0) begin
                if (we3 && wa3 == a) d = wd3;
                if (wb_valid && wb_addr == a) begin
                    d = wb_data;
                    b = 1'b0;
                end
            end
        end
        return {b, d};
    endfunction

    always_comb begin
        {busy1, rd1} = read_port(ra1);
        {busy2, rd2} = read_port(ra2);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb against an array/bitmap reference model,
// plus directed scenarios for the reset, forwarding and scoreboard corner cases.
module tb_regfile_sb;
    localparam int W    = 32;
    localparam int N    = 16;
    localparam int MAXP = 4;
    localparam int AW   = $clog2(N);
    localparam int CW   = $clog2(N + 1);
    localparam int TOPI = N - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          we3, mark_valid, wb_valid;
    logic [AW-1:0] wa3, mark_addr, wb_addr, ra1, ra2;
    logic [W-1:0]  wd3, wb_data, r15, rd1, rd2;
    logic          busy1, busy2, mark_ready, mark_err, wb_err;
    logic [N-1:0]  pending;
    logic [CW-1:0] pend_cnt;

    regfile_sb #(.WIDTH(W), .NREGS(N), .MAX_PEND(MAXP), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .mark_valid(mark_valid), .mark_addr(mark_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .r15(r15), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .pending(pending), .pend_cnt(pend_cnt),
        .mark_ready(mark_ready), .mark_err(mark_err), .wb_err(wb_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: architectural contents and reservation set
    logic [W-1:0] m_regs [N];
    logic [N-1:0] m_pend;
    logic [1:0]   exp_q[$];   // expected {mark_err, wb_err} for the next cycle
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input int a);
        if (a == TOPI) return r15;
        if (wb_valid && int'(wb_addr) == a) return wb_data;
        if (we3 && int'(wa3) == a) return wd3;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == TOPI) return 1'b0;
        if (wb_valid && int'(wb_addr) == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_pend = '0;
        exp_q.delete();
        exp_q.push_back(2'b00);
    endtask

    task automatic model_edge();
        logic accept;
        logic [1:0] flags;
        accept = mark_valid && ($countones(m_pend) < MAXP) && (int'(mark_addr) != TOPI)
                 && !m_pend[mark_addr];
        flags = {mark_valid && !accept, wb_valid && (int'(wb_addr) == TOPI || !m_pend[wb_addr])};
        exp_q.push_back(flags);
        if (we3 && int'(wa3) != TOPI) m_regs[wa3] = wd3;
        if (wb_valid && int'(wb_addr) != TOPI) m_regs[wb_addr] = wb_data;
        if (wb_valid) m_pend[wb_addr] = 1'b0;
        if (accept) m_pend[mark_addr] = 1'b1;
    endtask

    // driver: inputs are set at the falling edge; step checks, then clocks once
    task automatic idle();
        we3 = 0; wa3 = '0; wd3 = '0;
        mark_valid = 0; mark_addr = '0;
        wb_valid = 0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic step();
        logic [1:0] f;
        #1;
        f = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
        check("rd1", rd1, exp_rd(int'(ra1)));
        check("rd2", rd2, exp_rd(int'(ra2)));
        check("busy1", busy1, exp_busy(int'(ra1)));
        check("busy2", busy2, exp_busy(int'(ra2)));
        check("pending", pending, m_pend);
        check("pend_cnt", pend_cnt, $countones(m_pend));
        check("mark_ready", mark_ready, $countones(m_pend) < MAXP);
        check("mark_err", mark_err, f[1]);
        check("wb_err", wb_err, f[0]);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        int pl [$];
        idle();
        ra1 = '0; ra2 = '0; r15 = 32'h108;
        reset_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_pending", pending, 0);
        check("rst_cnt", pend_cnt, 0);
        check("rst_ready", mark_ready, 1);
        check("rst_errs", {mark_err, wb_err}, 0);
        reset_n = 1;
        @(negedge clk);

        // immediate write then read back; top index returns r15
        we3 = 1; wa3 = 3; wd3 = 32'hDEADBEEF;
        step();
        idle(); ra1 = 3; ra2 = 4'(TOPI);
        #1;
        check("d31_rd1", rd1, 32'hDEADBEEF);
        check("d31_busy1", busy1, 0);
        check("d31_rd2", rd2, 32'h108);
        step();

        // reserve 5, observe busy, writeback with forwarding
        mark_valid = 1; mark_addr = 5;
        step();
        idle(); ra1 = 5;
        #1;
        check("d32_busy1", busy1, 1);
        check("d32_pending", pending, 16'h0020);
        check("d32_cnt", pend_cnt, 1);
        wb_valid = 1; wb_addr = 5; wb_data = 32'h55;
        #1;
        check("d32_fwd_rd1", rd1, 32'h55);
        check("d32_fwd_busy1", busy1, 0);
        step();
        idle();
        #1;
        check("d32_cleared", pending, 0);
        step();

        // fill the scoreboard, then a rejected mark
        for (int a = 1; a <= 4; a++) begin
            mark_valid = 1; mark_addr = 4'(a);
            step();
        end
        idle();
        #1;
        check("d33_cnt", pend_cnt, 4);
        check("d33_ready", mark_ready, 0);
        mark_valid = 1; mark_addr = 6;
        step();
        idle();
        #1;
        check("d33_mark_err", mark_err, 1);
        check("d33_cnt_held", pend_cnt, 4);
        step();
        for (int a = 1; a <= 4; a++) begin
            wb_valid = 1; wb_addr = 4'(a); wb_data = 32'(a * 3);
            step();
        end
        idle();

        // same-address we3/wb clash, then writeback to a free register
        mark_valid = 1; mark_addr = 7;
        step();
        idle();
        we3 = 1; wa3 = 7; wd3 = 32'h11; wb_valid = 1; wb_addr = 7; wb_data = 32'h22;
        step();
        idle(); ra1 = 7;
        #1;
        check("d34_reg7", rd1, 32'h22);
        check("d34_pend7", pending[7], 0);
        wb_valid = 1; wb_addr = 8; wb_data = 32'hAB;
        step();
        idle(); ra2 = 8;
        #1;
        check("d34_wb_err", wb_err, 1);
        check("d34_reg8", rd2, 32'hAB);
        step();
        #1;
        check("d34_wb_err_pulse", wb_err, 0);
        step();

        // asynchronous reset in mid-cycle drops reservations and contents
        we3 = 1; wa3 = 9; wd3 = 32'h99;
        step();
        idle();
        mark_valid = 1; mark_addr = 9;
        step();
        idle(); ra1 = 9;
        #2;
        reset_n = 0;
        #1;
        check("d35_pending", pending, 0);
        check("d35_reg9", rd1, 0);
        check("d35_cnt", pend_cnt, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        wb_valid = 1; wb_addr = 9; wb_data = 32'h5;
        step();
        idle();
        #1;
        check("d35_wb_err", wb_err, 1);
        step();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            pl.delete();
            for (int i = 0; i < N; i++) if (m_pend[i]) pl.push_back(i);
            we3 = ($urandom_range(0, 9) < 3);
            wa3 = AW'($urandom_range(0, N - 1));
            wd3 = $urandom;
            mark_valid = ($urandom_range(0, 1) == 1);
            mark_addr = AW'($urandom_range(0, N - 1));
            wb_valid = ($urandom_range(0, 9) < 4);
            if (pl.size() > 0 && $urandom_range(0, 3) != 0)
                wb_addr = AW'(pl[$urandom_range(0, pl.size() - 1)]);
            else
                wb_addr = AW'($urandom_range(0, N - 1));
            wb_data = $urandom;
            r15 = $urandom;
            case ($urandom_range(0, 3))
                0: ra1 = wa3;
                1: ra1 = wb_addr;
                default: ra1 = AW'($urandom_range(0, N - 1));
            endcase
            ra2 = ($urandom_range(0, 1) == 1) ? mark_addr : AW'($urandom_range(0, N - 1));
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
